cmlb_gen: RTL

//  Parametrised successor of the code MLB: N-way set-associative translation buffer for fetch,

---
 rtl/cmlb_gen.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cmlb_gen.sv
// cmlb_gen: set-associative fetch translation buffer (code MLB successor).
//   Registered 1-cycle lookup, per-way age LRU, fill/update-in-place,
//   single-entry invalidate, restartable init/flush sweep.
//   Optional macro CMLB_GEN_ASID_EN adds per-entry ASID storage and
//   matching; data[DATA_W-1] marks a global entry that matches any ASID.
// Ports:
//   clk, rst (sync, active-low)        clock / reset
//   stall                              freezes lookup result registers
//   lkp_en/lkp_mode/lkp_addr/lkp_asid  lookup request; lkp_rdy = accepted
//   lkp_vld/lkp_hit/lkp_data           lookup result, 1 cycle after accept
//   wr_en/wr_mode/wr_addr/wr_data      fill / update
//   inv_en                             invalidate entry at wr_mode/wr_addr
//   flush                              invalidate all (restarts sweep)
//   busy                               init/flush sweep in progress
module cmlb_gen #(
   parameter int WAYS      = 8,
   parameter int SETS_LOG2 = 8,
   parameter int VA_W      = 65,
   parameter int DATA_W    = 64,
   parameter int ASID_W    = 21
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              lkp_en,
   output logic              lkp_rdy,
   input  logic              lkp_mode,
   input  logic [VA_W-1:0]   lkp_addr,
   input  logic [ASID_W-1:0] lkp_asid,
   output logic              lkp_vld,
   output logic              lkp_hit,
   output logic [DATA_W-1:0] lkp_data,
   input  logic              wr_en,
   input  logic              wr_mode,
   input  logic [VA_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              inv_en,
   input  logic              flush,
   output logic              busy
);
   localparam int SETS   = 1 << SETS_LOG2;
   localparam int AW     = $clog2(WAYS);
   localparam int TAG_W  = VA_W - 4 - SETS_LOG2;   // mode1 tag, the wider one
   localparam int TAG0_W = VA_W - 14 - SETS_LOG2;

   typedef enum logic [0:0] {INIT, RUN} state_t;
   state_t state, state_nxt;
   logic [SETS_LOG2-1:0] count, count_nxt;

   // entry storage
   logic [WAYS-1:0]   vld_q  [SETS];
   logic [WAYS-1:0]   mode_q [SETS];
   logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
   logic [DATA_W-1:0] data_q [SETS][WAYS];
   logic [AW-1:0]     age_q  [SETS][WAYS];
`ifdef CMLB_GEN_ASID_EN
   logic [ASID_W-1:0] asid_q [SETS][WAYS];
`endif

   // wr/inv and lookup are mutually exclusive in effect, so one address
   // path serves all of them; wr/inv take it when present.
   logic                 op_mode;
   logic [VA_W-1:0]      op_addr;
   logic [SETS_LOG2-1:0] op_idx;
   logic [TAG_W-1:0]     op_tag;
   logic [WAYS-1:0]      match;
   logic                 hit_any;
   logic [AW-1:0]        hit_way, vic_way, tgt_way, old_age;
   logic [DATA_W-1:0]    hit_data;
   logic [AW-1:0]        age_new [WAYS];
   logic                 unused_bits;

   assign busy    = (state == INIT);
   assign lkp_rdy = lkp_en & ~busy & ~flush & ~wr_en & ~inv_en & ~stall;
   assign op_mode = (wr_en | inv_en) ? wr_mode : lkp_mode;
   assign op_addr = (wr_en | inv_en) ? wr_addr : lkp_addr;

`ifdef CMLB_GEN_ASID_EN
   assign unused_bits = ^op_addr[3:0];
`else
   assign unused_bits = ^{op_addr[3:0], lkp_asid};
`endif

   always_comb begin
      op_idx = op_mode ? op_addr[4 +: SETS_LOG2] : op_addr[14 +: SETS_LOG2];
      op_tag = op_mode ? op_addr[VA_W-1 -: TAG_W]
                       : {{(TAG_W-TAG0_W){1'b0}}, op_addr[VA_W-1 -: TAG0_W]};
   end

   // Way match, hit payload and victim (the age-0 way of the permutation).
   always_comb begin
      match    = '0;
      hit_way  = '0;
      vic_way  = '0;
      hit_data = '0;
      for (int w = 0; w < WAYS; w++) begin
         match[w] = vld_q[op_idx][w] && (mode_q[op_idx][w] == op_mode) &&
                    (tag_q[op_idx][w] == op_tag);
`ifdef CMLB_GEN_ASID_EN
         if ((asid_q[op_idx][w] != lkp_asid) && !data_q[op_idx][w][DATA_W-1])
            match[w] = 1'b0;
`endif
         if (match[w]) begin
            hit_way  = AW'(w);
            hit_data = data_q[op_idx][w];
         end
         if (age_q[op_idx][w] == '0) vic_way = AW'(w);
      end
   end

   assign hit_any = |match;
   assign tgt_way = hit_any ? hit_way : vic_way;
   assign old_age = age_q[op_idx][tgt_way];

   // Touched way becomes youngest; only ways younger than it shift down,
   // which keeps the set a permutation of 0..WAYS-1.
   always_comb begin
      for (int v = 0; v < WAYS; v++) begin
         if (AW'(v) == tgt_way)             age_new[v] = AW'(WAYS-1);
         else if (age_q[op_idx][v] > old_age) age_new[v] = age_q[op_idx][v] - 1'b1;
         else                               age_new[v] = age_q[op_idx][v];
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      case (state)
         INIT: if (count == SETS_LOG2'(SETS-1)) state_nxt = RUN;
               else                             count_nxt = count + 1'b1;
         default: ;
      endcase
      if (flush) begin
         state_nxt = INIT;
         count_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= INIT;
         count    <= '0;
         lkp_vld  <= 1'b0;
         lkp_hit  <= 1'b0;
         lkp_data <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         if (!stall) begin
            lkp_vld  <= lkp_rdy;
            lkp_hit  <= lkp_rdy & hit_any;
            lkp_data <= (lkp_rdy && hit_any) ? hit_data : '0;
         end
      end
   end

   // Storage is not reset; the sweep clears it one set per cycle.
   always_ff @(posedge clk) begin
      if (rst && !flush) begin
         if (busy) begin
            vld_q[count] <= '0;
            for (int w = 0; w < WAYS; w++) age_q[count][w] <= AW'(w);
         end else if (wr_en) begin
            vld_q[op_idx][tgt_way]  <= 1'b1;
            mode_q[op_idx][tgt_way] <= op_mode;
            tag_q[op_idx][tgt_way]  <= op_tag;
            data_q[op_idx][tgt_way] <= wr_data;
`ifdef CMLB_GEN_ASID_EN
            asid_q[op_idx][tgt_way] <= lkp_asid;
`endif
            for (int w = 0; w < WAYS; w++) age_q[op_idx][w] <= age_new[w];
         end else if (inv_en) begin
            if (hit_any) vld_q[op_idx][hit_way] <= 1'b0;
         end else if (lkp_rdy && hit_any) begin
            for (int w = 0; w < WAYS; w++) age_q[op_idx][w] <= age_new[w];
         end
      end
   end
endmodule
